// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: issues regfile operands to a combinational ALU and writes back.
// Optional N/Z flag output enabled by defining ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rn,
    input  logic [AW-1:0] cmd_rm,
    input  logic          cmd_imm_sel,
    input  logic [7:0]    cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_rd,
    output logic [31:0]   rsp_data,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic [1:0]    flags_nz,
`endif
    output logic [31:0]   alu_operand1,
    output logic [31:0]   alu_operand2,
    output logic [1:0]    alu_control,
    input  logic [31:0]   alu_result,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [1:0]    ctl_q, ctl_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_rd_q, rsp_rd_d;
    logic [31:0]   regs_q [NREGS];
    logic [31:0]   regs_d [NREGS];
    logic          wb;
`ifdef ALU_ISSUE_FLAGS_EN
    logic [1:0]    flags_q, flags_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        ctl_d       = ctl_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        wb          = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    state_d = EXEC;
                    ready_d = 1'b0;
                    rd_d    = cmd_rd;
                    ctl_d   = cmd_op;
                    op1_d   = regs_q[cmd_rn];
                    op2_d   = cmd_imm_sel ? {24'b0, cmd_imm}
                                          : regs_q[cmd_rm];
                    cnt_d   = 4'(ALU_LAT - 1);
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    wb          = 1'b1;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_result;
                    rsp_rd_d    = rd_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        regs_d = regs_q;
        // Writeback is applied last so it wins over a same-edge preload.
        if (wr_en) regs_d[wr_addr] = wr_data;
        if (wb)    regs_d[rd_q]    = alu_result;

`ifdef ALU_ISSUE_FLAGS_EN
        flags_d = flags_q;
        if (wb) flags_d = {alu_result[31], alu_result == 32'd0};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctl_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            flags_q     <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            ctl_q       <= ctl_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            regs_q      <= regs_d;
`ifdef ALU_ISSUE_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign cmd_ready    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_rd       = rsp_rd_q;
    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign alu_control  = ctl_q;
    assign dbg_data     = regs_q[dbg_addr];
`ifdef ALU_ISSUE_FLAGS_EN
    assign flags_nz     = flags_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with ALU_LAT=1, one with ALU_LAT=3.
// Flag checks are compiled in when ALU_ISSUE_FLAGS_EN is defined.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cv0, cv3;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic        cmd_imm_sel;
    logic [7:0]  cmd_imm;
    logic        rsp_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  dbg_addr;

    logic        rdy0, rv0, rdy3, rv3;
    logic [2:0]  rrd0, rrd3;
    logic [31:0] rdat0, rdat3;
    logic [31:0] a1_0, a2_0, a1_3, a2_3;
    logic [1:0]  ctl0, ctl3;
    logic [31:0] res0, res3;
    logic [31:0] dbg0, dbg3;
`ifdef ALU_ISSUE_FLAGS_EN
    logic [1:0]  fl0, fl3;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int acc0   = 0;
    int rvhi3  = 0;

    function automatic logic [31:0] alu_f(input logic [1:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            default: return b;
        endcase
    endfunction

    assign res0 = alu_f(ctl0, a1_0, a2_0);
    assign res3 = alu_f(ctl3, a1_3, a2_3);

    alu_issue_ctrl #(.ALU_LAT(1), .NREGS(8)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv0), .cmd_ready(rdy0),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .rsp_valid(rv0), .rsp_ready(rsp_ready),
        .rsp_rd(rrd0), .rsp_data(rdat0),
`ifdef ALU_ISSUE_FLAGS_EN
        .flags_nz(fl0),
`endif
        .alu_operand1(a1_0), .alu_operand2(a2_0),
        .alu_control(ctl0), .alu_result(res0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    alu_issue_ctrl #(.ALU_LAT(3), .NREGS(8)) u3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv3), .cmd_ready(rdy3),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .rsp_valid(rv3), .rsp_ready(rsp_ready),
        .rsp_rd(rrd3), .rsp_data(rdat3),
`ifdef ALU_ISSUE_FLAGS_EN
        .flags_nz(fl3),
`endif
        .alu_operand1(a1_3), .alu_operand2(a2_3),
        .alu_control(ctl3), .alu_result(res3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg3)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (cv0 && rdy0) acc0++;
        if (rv3) rvhi3++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Returns at #1 after the accept edge.
    task automatic cmd(input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rn, input logic [2:0] rm,
                       input logic isel, input logic [7:0] imm,
                       input bit on3, input bit hold);
        int n;
        cmd_op      = op;
        cmd_rd      = rd;
        cmd_rn      = rn;
        cmd_rm      = rm;
        cmd_imm_sel = isel;
        cmd_imm     = imm;
        if (on3) cv3 = 1'b1;
        else     cv0 = 1'b1;
        n = 0;
        while (!(on3 ? rdy3 : rdy0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("acc_tmo", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) begin
            cv0 = 1'b0;
            cv3 = 1'b0;
        end
    endtask

    task automatic run0(input string tag, input logic [1:0] op,
                        input logic [2:0] rd, input logic [2:0] rn,
                        input logic [2:0] rm, input logic isel,
                        input logic [7:0] imm, input logic [31:0] exp,
                        input logic [1:0] fexp);
        int lat;
        cmd(op, rd, rn, rm, isel, imm, 1'b0, 1'b0);
        lat = 0;
        while (!rv0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_data"}, rdat0, exp);
        chk({tag, "_rd"}, {29'd0, rrd0}, {29'd0, rd});
`ifdef ALU_ISSUE_FLAGS_EN
        chk({tag, "_nz"}, {30'd0, fl0}, {30'd0, fexp});
`else
        if (fexp === 2'bxx) chk({tag, "_nzx"}, 32'd0, 32'd1);
`endif
        @(posedge clk); #1;
        chk({tag, "_rvlo"}, {31'd0, rv0}, 32'd0);
        dbg_addr = rd;
        #1;
        chk({tag, "_reg"}, dbg0, exp);
    endtask

    initial begin
        int a0, b0;
        rst_n = 1'b0;
        cv0 = 1'b0; cv3 = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0;
        rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        dbg_addr = '0;

        #12;
        chk("rst_rdy", {31'd0, rdy0}, 32'd0);
        chk("rst_rv", {31'd0, rv0}, 32'd0);
        chk("rst_op1", a1_0, 32'd0);
        chk("rst_dbg", dbg0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_up", {31'd0, rdy0}, 32'd1);

        preload(3'd0, 32'd10);
        preload(3'd1, 32'd20);
        dbg_addr = 3'd1;
        #1;
        chk("pre_r1", dbg0, 32'd20);

        run0("add", 2'b00, 3'd2, 3'd0, 3'd1, 1'b0, 8'd0,
             32'd30, 2'b00);
        run0("sub", 2'b01, 3'd3, 3'd1, 3'd0, 1'b0, 8'd0,
             32'd10, 2'b00);
        run0("subi", 2'b01, 3'd4, 3'd0, 3'd7, 1'b1, 8'd11,
             32'hFFFF_FFFF, 2'b10);
        preload(3'd5, 32'hFFFF_FFFF);
        run0("wrap", 2'b00, 3'd5, 3'd5, 3'd0, 1'b1, 8'd1,
             32'd0, 2'b01);

        // Backpressure with the next command held on the channel.
        rsp_ready = 1'b0;
        a0 = acc0;
        cmd(2'b00, 3'd6, 3'd0, 3'd1, 1'b0, 8'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv", {31'd0, rv0}, 32'd1);
            chk("bp_data", rdat0, 32'd30);
            chk("bp_rdy", {31'd0, rdy0}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        cv0 = 1'b0;
        @(posedge clk); #1;
        chk("bp_rvlo", {31'd0, rv0}, 32'd0);
        chk("bp_acc", acc0 - a0, 32'd1);

        // Preload to rd on the writeback edge loses to the writeback.
        cmd(2'b00, 3'd7, 3'd0, 3'd1, 1'b0, 8'd0, 1'b0, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 3'd7;
        wr_data = 32'h0000_DEAD;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("col_rv", {31'd0, rv0}, 32'd1);
        dbg_addr = 3'd7;
        #1;
        chk("col_r7", dbg0, 32'd30);
        chk("col_u3r7", dbg3, 32'h0000_DEAD);
        @(posedge clk); #1;

        run0("pass", 2'b10, 3'd1, 3'd0, 3'd0, 1'b1, 8'h5A,
             32'h0000_005A, 2'b00);

        // ALU_LAT=3 instance: operands held for three cycles.
        cmd(2'b01, 3'd2, 3'd1, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("l3_op1", a1_3, 32'd20);
            chk("l3_op2", a2_3, 32'd10);
            chk("l3_ctl", {30'd0, ctl3}, 32'd1);
            chk("l3_rvlo", {31'd0, rv3}, 32'd0);
            @(posedge clk); #1;
        end
        chk("l3_rv", {31'd0, rv3}, 32'd1);
        chk("l3_data", rdat3, 32'd10);
        chk("l3_rd", {29'd0, rrd3}, 32'd2);
        @(posedge clk); #1;
        dbg_addr = 3'd2;
        #1;
        chk("l3_reg", dbg3, 32'd10);

        // Reset during EXEC abandons the command.
        cmd(2'b00, 3'd6, 3'd0, 3'd1, 1'b0, 8'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        dbg_addr = 3'd0;
        #1;
        chk("mr_rv", {31'd0, rv3}, 32'd0);
        chk("mr_rdy", {31'd0, rdy3}, 32'd0);
        chk("mr_r0", dbg3, 32'd0);
        chk("mr_u0r0", dbg0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        b0 = rvhi3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_norsp", rvhi3 - b0, 32'd0);
        chk("mr_rdy1", {31'd0, rdy3}, 32'd1);
        dbg_addr = 3'd6;
        #1;
        chk("mr_r6", dbg3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
